fixed_56_accum: RTL and testbench



---
 rtl/fixed_56_accum.sv | 152 +++++++++++++++
 tb/tb_fixed_56_accum.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_56_accum.sv
// Streaming signed accumulator for Q47.8 product bursts. It produces one registered sum, beat count and overflow flag per frame.
// Optional build macro FIXED_ACCUM_SAT_EN: defined, an overflowing add clamps the sum; undefined, the sum wraps in two's complement.
module fixed_56_accum #(
    parameter int ACC_W = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [55:0]      p_in,
    input  logic             p_ovf,
    input  logic             in_last,
    output logic [ACC_W-1:0] sum_out,
    output logic [CNT_W-1:0] count_out,
    output logic             ovf_out,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic             busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q, in_ready_d;
    logic             sum_valid_q, sum_valid_d;
    logic             busy_q, busy_d;

    logic [ACC_W:0]   p_ext_s;
    logic [ACC_W:0]   sum_wide_s;
    logic             add_ovf_s;
    logic [ACC_W-1:0] add_res_s;
    logic [CNT_W-1:0] count_inc_s;
    logic             cnt_sat_s;
    logic             accept_s;

    // Widened add: one guard bit exposes signed overflow as a top-two-bit mismatch.
    always_comb begin
        p_ext_s    = {{(ACC_W+1-56){p_in[55]}}, p_in};
        sum_wide_s = {acc_q[ACC_W-1], acc_q} + p_ext_s;
        add_ovf_s  = sum_wide_s[ACC_W] ^ sum_wide_s[ACC_W-1];
`ifdef FIXED_ACCUM_SAT_EN
        if (add_ovf_s) begin
            add_res_s = sum_wide_s[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            add_res_s = sum_wide_s[ACC_W-1:0];
        end
`else
        add_res_s = sum_wide_s[ACC_W-1:0];
`endif
    end

    // Beat counter saturates at all-ones; a beat arriving at saturation flags overflow.
    always_comb begin
        if (count_q == CNT_MAX) begin
            count_inc_s = count_q;
            cnt_sat_s   = 1'b1;
        end else begin
            count_inc_s = count_q + CNT_ONE;
            cnt_sat_s   = 1'b0;
        end
    end

    // Frame sequencing and next-state datapath.
    always_comb begin
        accept_s = in_valid & in_ready_q;
        state_d  = state_q;
        acc_d    = acc_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ACCUM;
                    acc_d   = {ACC_W{1'b0}};
                    count_d = {CNT_W{1'b0}};
                    ovf_d   = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCUM: begin
                if (accept_s) begin
                    acc_d   = add_res_s;
                    count_d = count_inc_s;
                    ovf_d   = ovf_q | p_ovf | add_ovf_s | cnt_sat_s;
                    if (in_last) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ACCUM;
                    end
                end else begin
                    state_d = S_ACCUM;
                end
            end
            S_DONE: begin
                if (sum_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Handshake flags are decoded from the next state so they can be registered alongside it.
        in_ready_d  = (state_d == S_ACCUM);
        sum_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    // State and output registers; reset discards any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_q       <= {ACC_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            sum_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            sum_valid_q <= sum_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign sum_out   = acc_q;
    assign count_out = count_q;
    assign ovf_out   = ovf_q;
    assign sum_valid = sum_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_fixed_56_accum.sv
// Directed bench for fixed_56_accum. It drives a 64-bit and a 57-bit instance from shared stimulus.
// Both are checked against an exact-integer frame model and hand-computed results.
module tb_fixed_56_accum;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, p_ovf, in_last, sum_ready;
    logic [55:0] p_in;

    logic        rdy64, ovf64, sv64, busy64;
    logic [63:0] sum64;
    logic [15:0] cnt64;
    logic        rdy57, ovf57, sv57, busy57;
    logic [56:0] sum57;
    logic [15:0] cnt57;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    fixed_56_accum #(.ACC_W(64), .CNT_W(16)) dut64 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy64),
        .p_in(p_in), .p_ovf(p_ovf), .in_last(in_last), .sum_out(sum64), .count_out(cnt64),
        .ovf_out(ovf64), .sum_valid(sv64), .sum_ready(sum_ready), .busy(busy64));

    fixed_56_accum #(.ACC_W(57), .CNT_W(16)) dut57 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy57),
        .p_in(p_in), .p_ovf(p_ovf), .in_last(in_last), .sum_out(sum57), .count_out(cnt57),
        .ovf_out(ovf57), .sum_valid(sv57), .sum_ready(sum_ready), .busy(busy57));

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Exact-integer frame model: 0 idle, 1 collecting beats, 2 holding a result.
    int                   m_phase = 0;
    logic signed [127:0]  m_acc64 = '0, m_acc57 = '0;
    int                   m_cnt = 0;
    bit                   m_ovf64 = 1'b0, m_ovf57 = 1'b0;

    function automatic void add_beat(input logic signed [127:0] a, input logic signed [55:0] p,
                                     input int w, output logic signed [127:0] r, output bit o);
        logic signed [127:0] one, lim, t;
        one = 128'sd1;
        lim = one <<< (w - 1);
        t   = a + p;
        o   = 1'b0;
        r   = t;
        if (t > lim - one) begin
            o = 1'b1;
`ifdef FIXED_ACCUM_SAT_EN
            r = lim - one;
`else
            r = t - (lim + lim);
`endif
        end else if (t < -lim) begin
            o = 1'b1;
`ifdef FIXED_ACCUM_SAT_EN
            r = -lim;
`else
            r = t + (lim + lim);
`endif
        end
    endfunction

    always @(posedge clk) begin
        logic signed [127:0] r64, r57;
        bit o64, o57;
        if (rst) begin
            m_phase <= 0; m_acc64 <= '0; m_acc57 <= '0; m_cnt <= 0;
            m_ovf64 <= 1'b0; m_ovf57 <= 1'b0;
        end else if (m_phase == 0 && start) begin
            m_phase <= 1; m_acc64 <= '0; m_acc57 <= '0; m_cnt <= 0;
            m_ovf64 <= 1'b0; m_ovf57 <= 1'b0;
        end else if (m_phase == 1 && in_valid) begin
            add_beat(m_acc64, $signed(p_in), 64, r64, o64);
            add_beat(m_acc57, $signed(p_in), 57, r57, o57);
            m_acc64 <= r64;
            m_acc57 <= r57;
            m_cnt   <= (m_cnt == 65535) ? 65535 : m_cnt + 1;
            m_ovf64 <= m_ovf64 | p_ovf | o64 | (m_cnt == 65535);
            m_ovf57 <= m_ovf57 | p_ovf | o57 | (m_cnt == 65535);
            if (in_last) m_phase <= 2;
        end else if (m_phase == 2 && sum_ready) begin
            m_phase <= 0;
        end
    end

    // Per-cycle comparison of handshake flags always, and of results while one is presented.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("sum_valid64", {127'd0, sv64},   {127'd0, m_phase == 2});
            chk("sum_valid57", {127'd0, sv57},   {127'd0, m_phase == 2});
            chk("in_ready64",  {127'd0, rdy64},  {127'd0, m_phase == 1});
            chk("in_ready57",  {127'd0, rdy57},  {127'd0, m_phase == 1});
            chk("busy64",      {127'd0, busy64}, {127'd0, m_phase != 0});
            chk("busy57",      {127'd0, busy57}, {127'd0, m_phase != 0});
            if (m_phase == 2) begin
                chk("sum64",   {64'd0, sum64}, {64'd0, m_acc64[63:0]});
                chk("sum57",   {71'd0, sum57}, {71'd0, m_acc57[56:0]});
                chk("count64", {112'd0, cnt64}, 128'(m_cnt));
                chk("count57", {112'd0, cnt57}, 128'(m_cnt));
                chk("ovf64",   {127'd0, ovf64}, {127'd0, m_ovf64});
                chk("ovf57",   {127'd0, ovf57}, {127'd0, m_ovf57});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [55:0] p, input logic last, input logic ov);
        in_valid = 1'b1; p_in = p; in_last = last; p_ovf = ov;
        cyc();
        in_valid = 1'b0; p_in = 56'd0; in_last = 1'b0; p_ovf = 1'b0;
    endtask

    task automatic begin_frame();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic drain();
        sum_ready = 1'b1;
        cyc();
        sum_ready = 1'b0;
        chk("drained_valid", {127'd0, sv64}, 128'd0);
    endtask

    initial begin
        logic [63:0] held;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; p_ovf = 1'b0;
        in_last = 1'b0; sum_ready = 1'b0; p_in = 56'd0;
        cyc();
        cyc();
        cmp_en = 1'b1;
        chk("rst_sum",   {64'd0, sum64}, 128'd0);
        chk("rst_count", {112'd0, cnt64}, 128'd0);
        chk("rst_flags", {124'd0, ovf64, sv64, rdy64, busy64}, 128'd0);
        rst = 1'b0;
        cyc();

        // Basic frame of four 1.0 beats.
        begin_frame();
        beat(56'h100, 1'b0, 1'b0);
        beat(56'h100, 1'b0, 1'b0);
        beat(56'h100, 1'b0, 1'b0);
        beat(56'h100, 1'b1, 1'b0);
        chk("basic_valid", {127'd0, sv64}, 128'd1);
        chk("basic_sum",   {64'd0, sum64}, {64'd0, 64'h400});
        chk("basic_count", {112'd0, cnt64}, 128'd4);
        chk("basic_ovf",   {127'd0, ovf64}, 128'd0);
        drain();

        // Signed frame: 3.0 + (-4.0).
        begin_frame();
        beat(56'h300, 1'b0, 1'b0);
        beat(56'hFF_FFFF_FFFF_FC00, 1'b1, 1'b0);
        chk("signed_sum64", {64'd0, sum64}, {64'd0, 64'hFFFF_FFFF_FFFF_FF00});
        chk("signed_sum57", {71'd0, sum57}, {71'd0, 57'h1FF_FFFF_FFFF_FF00});
        chk("signed_count", {112'd0, cnt64}, 128'd2);
        drain();

        // Three maximal positive products overflow only the 57-bit instance.
        begin_frame();
        beat(56'h7F_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        beat(56'h7F_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        beat(56'h7F_FFFF_FFFF_FFFF, 1'b1, 1'b0);
`ifdef FIXED_ACCUM_SAT_EN
        chk("sat_sum57", {71'd0, sum57}, {71'd0, 57'h0FF_FFFF_FFFF_FFFF});
`else
        chk("wrap_sum57", {71'd0, sum57}, {71'd0, 57'h17F_FFFF_FFFF_FFFD});
`endif
        chk("big_ovf57", {127'd0, ovf57}, 128'd1);
        chk("big_sum64", {64'd0, sum64}, {64'd0, 64'h017F_FFFF_FFFF_FFFD});
        chk("big_ovf64", {127'd0, ovf64}, 128'd0);

        // Backpressure: stray beats and start pulses are ignored while the result is held.
        held = sum64;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; p_in = 56'h1234; start = 1'b1;
            cyc();
            chk("bp_valid", {127'd0, sv64}, 128'd1);
            chk("bp_ready", {127'd0, rdy64}, 128'd0);
            chk("bp_stable", {64'd0, sum64}, {64'd0, held});
        end
        in_valid = 1'b0; p_in = 56'd0; start = 1'b0;
        drain();
        chk("bp_idle_busy", {127'd0, busy64}, 128'd0);

        // Multiplier overflow on the middle beat only.
        begin_frame();
        beat(56'h5, 1'b0, 1'b0);
        beat(56'h6, 1'b0, 1'b1);
        beat(56'h7, 1'b1, 1'b0);
        chk("povf_sum",   {64'd0, sum64}, 128'd18);
        chk("povf_count", {112'd0, cnt64}, 128'd3);
        chk("povf_flag",  {127'd0, ovf64}, 128'd1);
        drain();

        // Beats offered while idle must not be accepted.
        in_valid = 1'b1; p_in = 56'h999;
        cyc();
        in_valid = 1'b0; p_in = 56'd0;

        // Reset in the middle of a frame discards it; reset outweighs a concurrent beat.
        begin_frame();
        beat(56'h40, 1'b0, 1'b0);
        beat(56'h40, 1'b0, 1'b0);
        rst = 1'b1; in_valid = 1'b1; p_in = 56'h40;
        cyc();
        rst = 1'b0; in_valid = 1'b0; p_in = 56'd0;
        chk("mid_rst_sum",   {64'd0, sum64}, 128'd0);
        chk("mid_rst_count", {112'd0, cnt64}, 128'd0);
        chk("mid_rst_flags", {124'd0, ovf64, sv64, rdy64, busy64}, 128'd0);
        begin_frame();
        beat(56'h80, 1'b1, 1'b0);
        chk("one_beat_sum",   {64'd0, sum64}, 128'h80);
        chk("one_beat_count", {112'd0, cnt64}, 128'd1);
        drain();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
